beat_generator: RTL
===================

Name: beat_generator

Overview:
- Downstream consumer of the BPM counter stage: takes the 34-bit beat period (clock cycles per beat) and its change strobe, and produces the metronome beat timing.
- Emits a one-cycle beat pulse, a one-cycle accent pulse on the first beat of each bar, the current beat index and a stretched LED drive.
- Its outputs feed the sound/LED/display stages.

Parameters:
- CNT_W, 34, width of period register and phase counter; matches the BPM counter output width
- IDX_W, 4, width of beats-per-bar input and beat index
- MIN_PERIOD, 2, smallest legal period in cycles; must be >= 2
- LED_CYCLES, 2500000, length of the o_led stretch in cycles; must be >= 1

Ports:
- i_clk  in  1  system clock; single clock domain
- i_reset_n  in  1  asynchronous, active-low reset
- i_enable  in  1  level; 1 = metronome running
- i_bpm_counter  in  CNT_W  beat period in clock cycles
- i_bpm_changed  in  1  one-cycle strobe; i_bpm_counter holds a new value this cycle
- i_beats_per_bar  in  IDX_W  beats per bar; 0 is treated as 1
- o_beat  out  1  one-cycle pulse per beat
- o_accent  out  1  one-cycle pulse, coincident with o_beat, on beat index 0
- o_beat_index  out  IDX_W  index of the most recent beat, 0..bpb-1
- o_led  out  1  high for LED_CYCLES cycles from each o_beat
- o_period_valid  out  1  registered; 1 when period_reg >= MIN_PERIOD

Behaviour:
- Reset (async, i_reset_n=0):
  - period_reg=0, phase=0, state=IDLE.
  - o_beat=0, o_accent=0, o_beat_index=0, o_led=0, o_led counter=0, o_period_valid=0.
  - Reset mid-run aborts immediately; no pulse is emitted on release.
- Period latch:
  - At any clock edge with i_bpm_changed=1, period_reg <= i_bpm_counter, in any state.
  - o_period_valid is updated at that same edge.
- FSM states: IDLE, RUN. "valid" below means the next-cycle value of (period_reg >= MIN_PERIOD).
  - IDLE -> RUN when i_enable=1 and valid. At that edge: o_beat=1, o_accent=1, o_beat_index=0, phase=0. The first beat therefore appears 1 cycle after the enable condition is sampled.
  - RUN -> IDLE when i_enable=0 or not valid. At that edge: phase=0, o_beat=0, o_accent=0. o_beat_index holds its value; o_led finishes its current stretch.
- RUN counting:
  - phase increments by 1 per cycle.
  - When phase == period_reg-1 (no underflow, since period >= 2): phase <= 0 and o_beat <= 1.
  - Index: if o_beat_index >= max(i_beats_per_bar,1)-1, it wraps to 0 and o_accent <= 1; otherwise it increments.
  - i_beats_per_bar is sampled at each beat, so lowering it mid-bar wraps at the next beat.
- Beat spacing: consecutive o_beat pulses are exactly period_reg cycles apart.
- i_bpm_changed in RUN (resync):
  - phase <= 0 and no beat is emitted that cycle, even if the terminal count coincides (change wins).
  - o_beat_index is unchanged.
  - The next o_beat rises exactly P_new cycles after the edge that sampled the strobe, provided the new period is valid; otherwise the FSM goes to IDLE.
- i_enable=0 and i_bpm_changed together: the latch happens and the FSM goes to IDLE.
- LED stretch:
  - On o_beat, the counter loads LED_CYCLES and o_led=1.
  - The counter decrements each cycle; o_led=0 when it reaches 0.
  - A new beat retriggers (reloads) the counter.
  - If LED_CYCLES >= period, o_led stays continuously high.
- Arithmetic: all period/phase arithmetic is unsigned CNT_W; the phase counter never exceeds period_reg-1.

Test Plan:
1. Reset, then i_bpm_changed pulse with i_bpm_counter=10, bpb=4, enable=1 -> first o_beat+o_accent 1 cycle after the valid period is sampled; o_beat every 10 cycles; o_beat_index 0,1,2,3,0; o_accent only at index 0.
2. Running at P=10; strobe i_bpm_changed with 6 when phase=4 -> no beat at the old terminal; next o_beat exactly 6 cycles after the strobe edge; index continues, not reset.
3. i_bpm_changed with value 1 (< MIN_PERIOD) while running -> o_period_valid=0, FSM IDLE, no further o_beat; a later strobe with 8 plus enable -> beat 1 cycle later, index 0, accent.
4. P=10, bpb=4, reduce bpb to 2 while index=2 -> next beat wraps to index 0 with o_accent; bpb=0 -> every beat accented, index stays 0.
5. LED_CYCLES=3, P=10 -> o_led high 3 cycles per beat; LED_CYCLES=15 -> o_led continuously high; deassert enable -> o_led drops 15 cycles after the last beat.
6. Assert i_reset_n=0 mid-phase (phase=5) -> all outputs 0 immediately (asynchronously); after release with enable=1, no beat until i_bpm_changed supplies a valid period.

Source files
------------

// File: rtl/beat_generator.sv
// Metronome beat timing: turns a beat period in clock cycles into beat/accent
// pulses, a running beat index and a stretched LED drive.
module beat_generator #(
    parameter int CNT_W      = 34,
    parameter int IDX_W      = 4,
    parameter int MIN_PERIOD = 2,
    parameter int LED_CYCLES = 2500000
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_bpm_counter,
    input  logic             i_bpm_changed,
    input  logic [IDX_W-1:0] i_beats_per_bar,
    output logic             o_beat,
    output logic             o_accent,
    output logic [IDX_W-1:0] o_beat_index,
    output logic             o_led,
    output logic             o_period_valid
);

    localparam int LED_W = $clog2(LED_CYCLES + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] period_r, period_s;
    logic [CNT_W-1:0] phase_r, phase_s;
    logic             beat_r, beat_s;
    logic             accent_r, accent_s;
    logic             valid_r, valid_s;
    logic             led_r, led_s;
    logic [IDX_W-1:0] idx_r, idx_s;
    logic [LED_W-1:0] led_cnt_r, led_cnt_s;

    // Highest beat index in a bar; a bar length of 0 behaves as 1.
    function automatic logic [IDX_W-1:0] last_index(input logic [IDX_W-1:0] bpb);
        logic [IDX_W-1:0] res;
        if (bpb == {IDX_W{1'b0}}) begin
            res = {IDX_W{1'b0}};
        end else begin
            res = bpb - IDX_W'(1);
        end
        return res;
    endfunction

    // Next-state, period latch, beat counting and LED stretch.
    always_comb begin
        state_s   = state_r;
        phase_s   = phase_r;
        beat_s    = 1'b0;
        accent_s  = 1'b0;
        idx_s     = idx_r;
        led_s     = 1'b0;
        led_cnt_s = led_cnt_r;

        if (i_bpm_changed) begin
            period_s = i_bpm_counter;
        end else begin
            period_s = period_r;
        end
        valid_s = (period_s >= CNT_W'(MIN_PERIOD));

        case (state_r)
            ST_IDLE: begin
                phase_s = {CNT_W{1'b0}};
                if (i_enable && valid_s) begin
                    state_s  = ST_RUN;
                    beat_s   = 1'b1;
                    accent_s = 1'b1;
                    idx_s    = {IDX_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!i_enable || !valid_s) begin
                    state_s = ST_IDLE;
                    phase_s = {CNT_W{1'b0}};
                end else if (i_bpm_changed) begin
                    // A new period restarts the phase; it takes priority over a terminal count.
                    phase_s = {CNT_W{1'b0}};
                end else if (phase_r == period_r - CNT_W'(1)) begin
                    phase_s = {CNT_W{1'b0}};
                    beat_s  = 1'b1;
                    if (idx_r >= last_index(i_beats_per_bar)) begin
                        idx_s    = {IDX_W{1'b0}};
                        accent_s = 1'b1;
                    end else begin
                        idx_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    phase_s = phase_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                phase_s = {CNT_W{1'b0}};
            end
        endcase

        if (beat_s) begin
            led_cnt_s = LED_W'(LED_CYCLES);
            led_s     = 1'b1;
        end else if (led_cnt_r != {LED_W{1'b0}}) begin
            led_cnt_s = led_cnt_r - LED_W'(1);
            led_s     = (led_cnt_r != LED_W'(1));
        end else begin
            led_cnt_s = {LED_W{1'b0}};
            led_s     = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r   <= ST_IDLE;
            period_r  <= {CNT_W{1'b0}};
            phase_r   <= {CNT_W{1'b0}};
            beat_r    <= 1'b0;
            accent_r  <= 1'b0;
            valid_r   <= 1'b0;
            led_r     <= 1'b0;
            idx_r     <= {IDX_W{1'b0}};
            led_cnt_r <= {LED_W{1'b0}};
        end else begin
            state_r   <= state_s;
            period_r  <= period_s;
            phase_r   <= phase_s;
            beat_r    <= beat_s;
            accent_r  <= accent_s;
            valid_r   <= valid_s;
            led_r     <= led_s;
            idx_r     <= idx_s;
            led_cnt_r <= led_cnt_s;
        end
    end

    assign o_beat         = beat_r;
    assign o_accent       = accent_r;
    assign o_beat_index   = idx_r;
    assign o_led          = led_r;
    assign o_period_valid = valid_r;

endmodule
